// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall thermometer, registered flush/redirect,
// stall-duration counter. Define PIPE_CTRL_WATCHDOG_EN to add the stall watchdog.
//
// state | meaning
// RUN   | normal operation, stall follows stall_req_i
// FLUSH | flush_o asserted, stalls suppressed, flush counter running
module pipe_ctrl #(
  parameter int                 NSTAGE    = 6,
  parameter int                 PC_W      = 32,
  parameter int                 FLUSH_CYC = 1,
  parameter int                 CNT_W     = 16,
  parameter int                 TIMEOUT   = 255,
  parameter logic [PC_W-1:0]    WD_PC     = 32'h0000_0180
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NSTAGE-1:0] stall_req_i,
  input  logic              flush_req_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [PC_W-1:0]   new_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              wd_timeout_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [NSTAGE-1:0] therm;
  logic              any_stall;
  logic              in_run;

  assign any_stall = |stall_req_i;
  assign in_run    = (state_q == RUN);

  // Stage k stalling forces every older stage (lower index) to hold as well.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    therm = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc      = acc | stall_req_i[i];
      therm[i] = acc;
    end
  end

  assign stall_o = (in_run && !rst_i) ? therm : '0;

`ifdef PIPE_CTRL_WATCHDOG_EN
  logic wd_q, wd_d;
  logic wd_fire;

  assign wd_fire = in_run && any_stall && (scnt_q == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
`ifdef PIPE_CTRL_WATCHDOG_EN
    wd_d    = wd_q;
`endif

    if (in_run && any_stall) begin
      scnt_d = (scnt_q == CNT_MAX) ? scnt_q : scnt_q + 1'b1;
    end else begin
      scnt_d = '0;
    end

    case (state_q)
      RUN: begin
        state_d = RUN;
      end
      FLUSH: begin
        if (fcnt_q <= 4'd1) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase

`ifdef PIPE_CTRL_WATCHDOG_EN
    if (wd_fire) begin
      state_d = FLUSH;
      fcnt_d  = FLUSH_LOAD;
      pc_d    = WD_PC;
      wd_d    = 1'b1;
    end
`endif

    // External redirect overrides the watchdog target but not its status bit.
    if (flush_req_i) begin
      state_d = FLUSH;
      fcnt_d  = FLUSH_LOAD;
      pc_d    = flush_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      scnt_q  <= scnt_d;
    end
  end

`ifdef PIPE_CTRL_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_timeout_o = wd_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{WD_PC, TIMEOUT};
  assign wd_timeout_o = 1'b0;
`endif

  assign flush_o     = (state_q == FLUSH);
  assign new_pc_o    = pc_q;
  assign stall_cnt_o = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYC=3, TIMEOUT=4, CNT_W=4).
// Covers both builds; the watchdog section follows PIPE_CTRL_WATCHDOG_EN.
module tb_pipe_ctrl;

  localparam int              NSTAGE    = 6;
  localparam int              PC_W      = 32;
  localparam int              FLUSH_CYC = 3;
  localparam int              CNT_W     = 4;
  localparam int              TIMEOUT   = 4;
  localparam logic [PC_W-1:0] WD_PC     = 32'h0000_0180;

  logic              clk_i;
  logic              rst_i;
  logic [NSTAGE-1:0] stall_req_i;
  logic              flush_req_i;
  logic [PC_W-1:0]   flush_pc_i;
  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic [PC_W-1:0]   new_pc_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              wd_timeout_o;

  int n_chk;
  int n_err;

  pipe_ctrl #(
    .NSTAGE   (NSTAGE),
    .PC_W     (PC_W),
    .FLUSH_CYC(FLUSH_CYC),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .WD_PC    (WD_PC)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_req_i (stall_req_i),
    .flush_req_i (flush_req_i),
    .flush_pc_i  (flush_pc_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .new_pc_o    (new_pc_o),
    .stall_cnt_o (stall_cnt_o),
    .wd_timeout_o(wd_timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst_i       = 1'b1;
    stall_req_i = 6'h3F;
    flush_req_i = 1'b1;
    flush_pc_i  = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_flush", 64'(flush_o), 64'h0);
    chk("rst_newpc", 64'(new_pc_o), 64'h0);
    chk("rst_scnt", 64'(stall_cnt_o), 64'h0);
    chk("rst_wd", 64'(wd_timeout_o), 64'h0);
    rst_i       = 1'b0;
    flush_req_i = 1'b0;
    stall_req_i = '0;
    step();

    // thermometer decode
    stall_req_i = 6'b001000; #1;
    chk("therm_001000", 64'(stall_o), 64'b001111);
    stall_req_i = 6'b000100; #1;
    chk("therm_000100", 64'(stall_o), 64'b000111);
    stall_req_i = 6'b000000; #1;
    chk("therm_zero", 64'(stall_o), 64'b000000);
    step();

    // stall counter
    stall_req_i = 6'b100010; #1;
    chk("therm_100010", 64'(stall_o), 64'b111111);
    chk("scnt_0", 64'(stall_cnt_o), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("scnt_%0d", i), 64'(stall_cnt_o), 64'(i));
    end
    stall_req_i = '0;
    step();
    chk("scnt_clear", 64'(stall_cnt_o), 64'd0);

`ifdef PIPE_CTRL_WATCHDOG_EN
    stall_req_i = 6'b000111;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("wd_scnt_%0d", i), 64'(stall_cnt_o), 64'(i));
      chk("wd_noflush", 64'(flush_o), 64'h0);
    end
    step();
    chk("wd_flush", 64'(flush_o), 64'h1);
    chk("wd_newpc", 64'(new_pc_o), 64'(WD_PC));
    chk("wd_status", 64'(wd_timeout_o), 64'h1);
    chk("wd_stall0", 64'(stall_o), 64'h0);
    step();
    chk("wd_flush2", 64'(flush_o), 64'h1);
    chk("wd_scnt_fl", 64'(stall_cnt_o), 64'd0);
    step();
    chk("wd_flush3", 64'(flush_o), 64'h1);
    step();
    chk("wd_flush_end", 64'(flush_o), 64'h0);
    stall_req_i = '0;
    step();
    chk("wd_sticky", 64'(wd_timeout_o), 64'h1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("wd_rst_clear", 64'(wd_timeout_o), 64'h0);
    step();
`else
    stall_req_i = 6'b000111;
    for (int i = 1; i <= 4; i++) step();
    chk("nowd_scnt4", 64'(stall_cnt_o), 64'd4);
    chk("nowd_noflush", 64'(flush_o), 64'h0);
    chk("nowd_stall", 64'(stall_o), 64'b000111);
    for (int i = 0; i < 16; i++) step();
    chk("nowd_sat", 64'(stall_cnt_o), 64'd15);
    chk("nowd_wd0", 64'(wd_timeout_o), 64'h0);
    stall_req_i = '0;
    step();
    chk("nowd_clear", 64'(stall_cnt_o), 64'd0);
`endif

    // single flush with concurrent stall request
    flush_req_i = 1'b1;
    flush_pc_i  = 32'h0000_4000;
    stall_req_i = 6'h3F; #1;
    chk("fl_same_cyc_stall", 64'(stall_o), 64'h3F);
    step();
    flush_req_i = 1'b0;
    flush_pc_i  = 32'hDEAD_0000;
    chk("fl_c1", 64'(flush_o), 64'h1);
    chk("fl_c1_pc", 64'(new_pc_o), 64'h4000);
    chk("fl_c1_stall", 64'(stall_o), 64'h0);
    chk("fl_c1_scnt", 64'(stall_cnt_o), 64'd1);
    step();
    chk("fl_c2", 64'(flush_o), 64'h1);
    chk("fl_c2_scnt", 64'(stall_cnt_o), 64'd0);
    chk("fl_c2_stall", 64'(stall_o), 64'h0);
    step();
    chk("fl_c3", 64'(flush_o), 64'h1);
    step();
    chk("fl_end", 64'(flush_o), 64'h0);
    chk("fl_end_pc", 64'(new_pc_o), 64'h4000);
    chk("fl_end_stall", 64'(stall_o), 64'h3F);
    chk("fl_end_scnt", 64'(stall_cnt_o), 64'd0);
    stall_req_i = '0;
    step();

    // retrigger in second flush cycle
    flush_req_i = 1'b1;
    flush_pc_i  = 32'h0000_4000;
    step();
    flush_req_i = 1'b0;
    step();
    chk("rt_c2", 64'(flush_o), 64'h1);
    flush_req_i = 1'b1;
    flush_pc_i  = 32'h0000_8000;
    step();
    flush_req_i = 1'b0;
    chk("rt_pc", 64'(new_pc_o), 64'h8000);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) step();
      chk($sformatf("rt_hold_%0d", i), 64'(flush_o), 64'h1);
    end
    step();
    chk("rt_end", 64'(flush_o), 64'h0);
    chk("rt_end_pc", 64'(new_pc_o), 64'h8000);

    // reset aborts an active flush
    flush_req_i = 1'b1;
    flush_pc_i  = 32'h0000_1234;
    step();
    flush_req_i = 1'b0;
    chk("ra_flush", 64'(flush_o), 64'h1);
    rst_i       = 1'b1;
    stall_req_i = 6'h3F; #1;
    chk("ra_stall_in_rst", 64'(stall_o), 64'h0);
    step();
    rst_i = 1'b0;
    chk("ra_flush0", 64'(flush_o), 64'h0);
    chk("ra_pc0", 64'(new_pc_o), 64'h0);
    chk("ra_scnt0", 64'(stall_cnt_o), 64'd0);
    chk("ra_wd0", 64'(wd_timeout_o), 64'h0);
    #1;
    chk("ra_run_stall", 64'(stall_o), 64'h3F);
    stall_req_i = '0;
    step();
    chk("ra_still_run", 64'(flush_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, 6, number of pipeline stages controlled; bit 0 = PC, bit NSTAGE-1 = last stage.
REQ-002 Parameter PC_W, 32, width of redirect PC.
REQ-003 Parameter FLUSH_CYC, 1, cycles flush is held asserted (1..15).
REQ-004 Parameter CNT_W, 16, width of stall-duration counter.
REQ-005 Parameter TIMEOUT, 255, consecutive stall cycles that trigger the watchdog (1..2^CNT_W-1).
REQ-006 Parameter WD_PC, 32'h0000_0180, redirect PC used on watchdog flush.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  reset: synchronous, active-high.
REQ-009 stall_req  input  NSTAGE  per-stage stall request, bit k from stage k, active-high.
REQ-010 flush_req  input  1  redirect/flush request, sampled each rising edge.
REQ-011 flush_pc  input  PC_W  redirect target, valid with flush_req.
REQ-012 stall  output  NSTAGE  per-stage hold, 1 = stage holds its register.
REQ-013 flush  output  1  pipeline flush, registered.
REQ-014 new_pc  output  PC_W  redirect target, valid while flush=1.
REQ-015 stall_cnt  output  CNT_W  consecutive cycles with any stall active.
REQ-016 wd_timeout  output  1  sticky watchdog status.

Function
REQ-017 FSM states RUN and FLUSH; reset state RUN.
REQ-018 In RUN, stall is combinational: k = highest set bit of stall_req -> stall[k:0]=1, stall[NSTAGE-1:k+1]=0; no bit set -> stall=0.
REQ-019 In FLUSH, stall SHALL be 0 regardless of stall_req.
REQ-020 flush_req=1 sampled at edge t (either state) -> state FLUSH from t+1, flush=1 for exactly FLUSH_CYC cycles, new_pc = flush_pc captured at t.
REQ-021 flush_req during FLUSH recaptures new_pc and restarts the FLUSH_CYC count (no gap in flush).
REQ-022 After the last FLUSH cycle with no new flush_req -> RUN; flush=0, new_pc holds last value.
REQ-023 flush_req and stall_req in the same RUN cycle: stall per REQ-018 that cycle; flush wins from next cycle.
REQ-024 stall_cnt increments each edge where state=RUN and |stall_req=1; clears to 0 otherwise (including any FLUSH cycle); saturates at 2^CNT_W-1, no wrap.
REQ-025 FLUSH_CYC down-counter SHALL be 4 bits; values outside 1..15 are illegal.

Reset
REQ-026 rst=1 at an edge -> state RUN, flush=0, new_pc=0, stall_cnt=0, wd_timeout=0, FLUSH count cleared; dominates flush_req and watchdog.
REQ-027 While rst=1, stall SHALL be 0 (combinational override).
REQ-028 rst mid-FLUSH aborts the flush; first post-reset cycle is RUN with flush=0.

Configuration
REQ-029 Macro PIPE_CTRL_WATCHDOG_EN.
REQ-030 Defined: when stall_cnt = TIMEOUT-1 and |stall_req=1 at an edge in RUN, that edge enters FLUSH with new_pc=WD_PC, sets wd_timeout=1 (sticky until rst); external flush_req at the same edge takes priority for new_pc, wd_timeout still sets.
REQ-031 Not defined: no watchdog logic, wd_timeout tied 0, stall_cnt saturates and stalls indefinitely.

Verification
REQ-032 rst then stall_req=6'b001000 -> stall=6'b001111; stall_req=6'b000100 -> 6'b000111; stall_req=0 -> 6'b000000.
REQ-033 stall_req=6'b100010 -> stall=6'b111111; stall_cnt 0,1,2,... while held, returns 0 one edge after stall_req=0.
REQ-034 FLUSH_CYC=3, flush_req pulse with flush_pc=32'h0000_4000 at edge t -> flush=1 cycles t+1..t+3, new_pc=32'h4000, stall=0 throughout even with stall_req=6'h3F.
REQ-035 Flush_req again at second FLUSH cycle with flush_pc=32'h8000 -> new_pc=32'h8000, flush held 3 further cycles.
REQ-036 PIPE_CTRL_WATCHDOG_EN, TIMEOUT=4, stall_req=6'b000111 held -> stall_cnt 1..3, then flush=1, new_pc=WD_PC, wd_timeout=1 until rst; without macro, stall_cnt keeps counting, wd_timeout=0.
REQ-037 rst asserted during FLUSH -> next cycle flush=0, stall_cnt=0, wd_timeout=0, state RUN.
